// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
//   Shared constants and helpers for the binary<->Gray converter.
//   Mode encodings:
//     MODE_B2G (0) : binary -> Gray
//     MODE_G2B (1) : Gray   -> binary
//   Helpers work on MAX_W-bit words. A caller with a narrower WIDTH zero-extends
//   its operand with a size cast and casts the result back to WIDTH. That is
//   exact for all three helpers because zero bits above WIDTH contribute nothing
//   to the shift, the prefix XOR or the bit-difference count.
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    // Widest supported code word
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB downwards: b[i] = ^g[MSB:i]
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when a and b differ in exactly one bit (equal words are not adjacent)
    function automatic logic is_adjacent(input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b);
        logic [MAX_W-1:0] diff;
        logic [31:0]      ones;
        diff = a ^ b;
        ones = 32'd0;
        for (int i = 0; i < MAX_W; i++) begin
            ones = ones + {31'd0, diff[i]};
        end
        return (ones == 32'd1);
    endfunction

endpackage

// File: rtl/gray_adj_check.sv
// -----------------------------------------------------------------------------
// gray_adj_check
//   Gray adjacency monitor. Remembers the last accepted Gray->binary input word
//   and flags a new Gray word that does not differ from it in exactly one bit.
//   Only instantiated when GRAY_ADJ_CHECK_EN is defined.
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous reset, active-high; clears history and hist_v
//   upd   in   1      a Gray->binary word is being accepted this cycle
//   word  in   WIDTH  incoming Gray word
//   err   out  1      word is not adjacent to the stored history (valid while
//                     the incoming word is a Gray->binary word)
// -----------------------------------------------------------------------------
module gray_adj_check
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [WIDTH-1:0] word,
    output logic             err
);

    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;
    logic             hist_v_q;
    logic             hist_v_d;

    // No history yet means nothing to compare against, so no error
    assign err = hist_v_q && !is_adjacent(MAX_W'(word), MAX_W'(hist_q));

    always_comb begin
        hist_d   = hist_q;
        hist_v_d = hist_v_q;
        if (upd) begin
            hist_d   = word;
            hist_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q   <= '0;
            hist_v_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            hist_v_q <= hist_v_d;
        end
    end

endmodule

// File: rtl/gray_codec_pipe.sv
// -----------------------------------------------------------------------------
// gray_codec_pipe
//   Two-stage pipelined binary<->Gray converter with valid/ready handshake on
//   both sides. Every word carries its own mode, so modes can be mixed freely
//   in a stream. Full throughput (one word per clock), two-cycle latency, and
//   lossless back-pressure.
//
//   Optional feature: define GRAY_ADJ_CHECK_EN to enable the Gray adjacency
//   monitor (gray_adj_check). Without it out_adj_err is tied to 0.
//
// Parameters
//   WIDTH        code word width, 2..64
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous reset, active-high
//   in_valid     in   1      input word valid
//   in_ready     out  1      block can accept input this cycle
//   in_data      in   WIDTH  word to convert
//   in_mode      in   1      0 = binary->Gray, 1 = Gray->binary
//   out_valid    out  1      converted word valid
//   out_ready    in   1      consumer accepts the output this cycle
//   out_data     out  WIDTH  converted word
//   out_mode     out  1      mode the word was converted with
//   out_adj_err  out  1      Gray adjacency violation flag
// -----------------------------------------------------------------------------
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_adj_err
);

    logic             vld_p1_q,  vld_p1_d;
    logic [WIDTH-1:0] data_p1_q, data_p1_d;
    logic             mode_p1_q, mode_p1_d;
    logic             err_p1_q,  err_p1_d;

    logic             vld_p2_q,  vld_p2_d;
    logic [WIDTH-1:0] data_p2_q, data_p2_d;
    logic             mode_p2_q, mode_p2_d;
    logic             err_p2_q,  err_p2_d;

    logic             s1_load;
    logic             s2_load;
    logic             in_fire;
    logic             adj_err_in;
    logic [WIDTH-1:0] conv_word;

    // A stage may load when it is empty or when its content moves on this cycle
    assign s2_load  = !vld_p2_q || out_ready;
    assign s1_load  = !vld_p1_q || s2_load;
    // Held high while rst is asserted so upstream never sees a stall during reset
    assign in_ready = rst || s1_load;
    assign in_fire  = in_valid && in_ready;

`ifdef GRAY_ADJ_CHECK_EN
    logic adj_err_raw;

    // The check is made as the word enters, against history from earlier words
    gray_adj_check #(
        .WIDTH (WIDTH)
    ) u_adj_check (
        .clk  (clk),
        .rst  (rst),
        .upd  (in_fire && (in_mode == MODE_G2B)),
        .word (in_data),
        .err  (adj_err_raw)
    );

    assign adj_err_in = (in_mode == MODE_G2B) && adj_err_raw;
`else
    assign adj_err_in = 1'b0;
`endif

    // ---- S1 -> S2 boundary: conversion ----
    always_comb begin
        if (mode_p1_q == MODE_G2B) begin
            conv_word = WIDTH'(gray2bin(MAX_W'(data_p1_q)));
        end else begin
            conv_word = WIDTH'(bin2gray(MAX_W'(data_p1_q)));
        end
    end

    always_comb begin
        vld_p1_d  = vld_p1_q;
        data_p1_d = data_p1_q;
        mode_p1_d = mode_p1_q;
        err_p1_d  = err_p1_q;
        vld_p2_d  = vld_p2_q;
        data_p2_d = data_p2_q;
        mode_p2_d = mode_p2_q;
        err_p2_d  = err_p2_q;

        // ---- input -> S1 ----
        if (s1_load) begin
            vld_p1_d = in_valid;
            if (in_valid) begin
                data_p1_d = in_data;
                mode_p1_d = in_mode;
                err_p1_d  = adj_err_in;
            end
        end

        // ---- S1 -> S2 ----
        if (s2_load) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                data_p2_d = conv_word;
                mode_p2_d = mode_p1_q;
                err_p2_d  = err_p1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            data_p1_q <= '0;
            mode_p1_q <= 1'b0;
            err_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            mode_p2_q <= 1'b0;
            err_p2_q  <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            data_p1_q <= data_p1_d;
            mode_p1_q <= mode_p1_d;
            err_p1_q  <= err_p1_d;
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            mode_p2_q <= mode_p2_d;
            err_p2_q  <= err_p2_d;
        end
    end

    // ---- S2 -> output ----
    assign out_valid   = vld_p2_q;
    assign out_data    = data_p2_q;
    assign out_mode    = mode_p2_q;
    assign out_adj_err = err_p2_q;

endmodule

// File: tb/tb_gray_codec_pipe.sv
module tb_gray_codec_pipe;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             out_adj_err;

    always #5 clk = ~clk;

    gray_codec_pipe #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_mode    (out_mode),
        .out_adj_err (out_adj_err)
    );

    typedef struct packed {
        logic [3:0] data;
        logic       mode;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] obs_data[$];
    logic       obs_err[$];

    int         errors = 0;
    int         checks = 0;

    bit         hold_prev = 1'b0;
    logic [3:0] held_data;
    logic       held_mode;
    logic       held_err;
    bit         last_in_fire = 1'b0;
    int         out_cnt = 0;

    logic [3:0] mhist = 4'd0;
    bit         mhist_v = 1'b0;

    // Reference: Gray code of b is b XOR floor(b/2)
    function automatic int ref_b2g(input int b);
        return b ^ (b / 2);
    endfunction

    // Reference: binary value is the one whose Gray code equals g
    function automatic int ref_g2b(input int g);
        for (int c = 0; c < 16; c++) begin
            if (ref_b2g(c) == g) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [3:0] d, input logic m);
        exp_t e;
        e.data = m ? 4'(ref_g2b(int'(d))) : 4'(ref_b2g(int'(d)));
        e.mode = m;
        e.err  = 1'b0;
`ifdef GRAY_ADJ_CHECK_EN
        if (m) begin
            if (mhist_v && ($countones(d ^ mhist) != 1)) e.err = 1'b1;
            mhist   = d;
            mhist_v = 1'b1;
        end
`endif
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        mhist     = 4'd0;
        mhist_v   = 1'b0;
        hold_prev = 1'b0;
    endtask

    // One clock: observe handshakes at the falling edge, return 1 unit after the rising edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_in_fire = 1'b0;
        if (!rst) begin
            if (hold_prev) begin
                chk("hold_valid", 64'(out_valid), 64'(1'b1));
                chk("hold_data", 64'(out_data), 64'(held_data));
                chk("hold_mode", 64'(out_mode), 64'(held_mode));
                chk("hold_err", 64'(out_adj_err), 64'(held_err));
            end
            if (out_valid && exp_q.size() == 0) begin
                chk("phantom_out", 64'(out_valid), 64'(1'b0));
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_mode", 64'(out_mode), 64'(e.mode));
                chk("out_adj_err", 64'(out_adj_err), 64'(e.err));
                obs_data.push_back(out_data);
                obs_err.push_back(out_adj_err);
                out_cnt++;
            end
            hold_prev = out_valid && !out_ready;
            held_data = out_data;
            held_mode = out_mode;
            held_err  = out_adj_err;
            if (in_valid && in_ready) begin
                last_in_fire = 1'b1;
                model_push(in_data, in_mode);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_in_fire) break;
        end
        chk("send_accept", 64'(last_in_fire), 64'(1'b1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_no_valid", 64'(out_valid), 64'(1'b0));
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        chk("in_ready_during_rst", 64'(in_ready), 64'(1'b1));
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] t4_w [4] = '{4'h3, 4'h9, 4'hC, 4'h6};
    logic [3:0] t6_d [5] = '{4'b0000, 4'b0001, 4'b0101, 4'b0111, 4'b0111};
    logic       t6_m [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef GRAY_ADJ_CHECK_EN
    logic       t6_e [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    logic       t6_e [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    initial begin
        int idx;
        int acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_mode", 64'(out_mode), 64'(1'b0));
        chk("rst_out_adj_err", 64'(out_adj_err), 64'(1'b0));
        chk("rst_in_ready_after", 64'(in_ready), 64'(1'b1));

        // 1: binary->Gray, two-cycle latency
        out_ready = 1'b1;
        send(4'b1011, 1'b0);
        chk("t1_lat1_valid", 64'(out_valid), 64'(1'b0));
        tick();
        chk("t1_lat2_valid", 64'(out_valid), 64'(1'b1));
        chk("t1_data", 64'(out_data), 64'(4'b1110));
        chk("t1_mode", 64'(out_mode), 64'(1'b0));
        tick();

        // 2: Gray->binary
        send(4'b1110, 1'b1);
        tick();
        chk("t2_valid", 64'(out_valid), 64'(1'b1));
        chk("t2_data", 64'(out_data), 64'(4'b1011));
        chk("t2_mode", 64'(out_mode), 64'(1'b1));
        drain();

        // 2b: round trip of all 16 values, streamed back to back
        obs_data.delete();
        out_ready = 1'b1;
        for (int v = 0; v < 32; v++) begin
            in_valid = 1'b1;
            in_mode  = (v >= 16);
            in_data  = (v < 16) ? 4'(v) : 4'(ref_b2g(v - 16));
            tick();
            chk("rt_accept", 64'(last_in_fire), 64'(1'b1));
        end
        drain();
        chk("rt_count", 64'(obs_data.size()), 64'd32);
        for (int v = 0; v < 16 && obs_data.size() == 32; v++) begin
            chk("rt_gray", 64'(obs_data[v]), 64'(ref_b2g(v)));
            chk("rt_back", 64'(obs_data[16 + v]), 64'(v));
        end

        // 3: stream 0..15, alternating mode, one output per cycle
        out_cnt   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_valid = (i < 16);
            in_data  = 4'(i);
            in_mode  = 1'(i % 2);
            tick();
            chk("t3_in_ready", 64'(in_ready), 64'(1'b1));
        end
        chk("t3_out_count", 64'(out_cnt), 64'd16);
        drain();

        // 4: back-pressure, 4 words offered over 5 stalled cycles
        obs_data.delete();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            in_data  = t4_w[idx % 4];
            in_mode  = 1'b0;
            tick();
            if (last_in_fire) idx++;
        end
        acc = idx;
        chk("t4_accepted", 64'(acc), 64'd2);
        chk("t4_in_ready", 64'(in_ready), 64'(1'b0));
        chk("t4_out_valid", 64'(out_valid), 64'(1'b1));
        chk("t4_out_data", 64'(out_data), 64'(ref_b2g(int'(t4_w[0]))));
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            in_valid = 1'b1;
            in_data  = t4_w[idx];
            tick();
            if (last_in_fire) idx++;
        end
        drain();
        chk("t4_count", 64'(obs_data.size()), 64'd4);
        for (int i = 0; i < 4 && obs_data.size() == 4; i++) begin
            chk("t4_order", 64'(obs_data[i]), 64'(ref_b2g(int'(t4_w[i]))));
        end

        // 5: reset with two words in flight
        out_ready = 1'b0;
        send(4'h5, 1'b0);
        send(4'h9, 1'b0);
        chk("t5_full_valid", 64'(out_valid), 64'(1'b1));
        do_reset();
        chk("t5_out_valid", 64'(out_valid), 64'(1'b0));
        chk("t5_out_data", 64'(out_data), 64'd0);
        chk("t5_out_mode", 64'(out_mode), 64'(1'b0));
        chk("t5_out_adj_err", 64'(out_adj_err), 64'(1'b0));
        chk("t5_in_ready", 64'(in_ready), 64'(1'b1));
        obs_data.delete();
        out_ready = 1'b1;
        send(4'b0110, 1'b1);
        drain();
        chk("t5_count", 64'(obs_data.size()), 64'd1);
        if (obs_data.size() == 1) chk("t5_data", 64'(obs_data[0]), 64'(4'b0100));

        // 6: adjacency flag sequence with a mode-0 word in between
        do_reset();
        obs_err.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(t6_d[i], t6_m[i]);
        end
        drain();
        chk("t6_count", 64'(obs_err.size()), 64'd5);
        for (int i = 0; i < 5 && obs_err.size() == 5; i++) begin
            chk("t6_err", 64'(obs_err[i]), 64'(t6_e[i]));
        end

        // Random traffic with random back-pressure
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_in_fire) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 4'($urandom);
                in_mode  = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
